// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM encoding
// and request legality helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Half accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic is_illegal_f3(input logic write, input logic [2:0] funct3);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = write;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, and
// load extraction with sign/zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en_c,
  output logic [31:0] wdata_aligned_c,
  output logic [31:0] load_data_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    byte_en_c       = 4'b0000;
    wdata_aligned_c = 32'h0;
    load_data_c     = 32'h0;
    case (funct3)
      F3_B: begin
        byte_en_c       = 4'b0001 << addr_lo;
        wdata_aligned_c = {4{wdata[7:0]}};
        load_data_c     = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        byte_en_c       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_aligned_c = {2{wdata[15:0]}};
        load_data_c     = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        byte_en_c       = 4'b1111;
        wdata_aligned_c = wdata;
        load_data_c     = rword;
      end
      F3_BU:   load_data_c = {24'h0, byte_sel};
      F3_HU:   load_data_c = {16'h0, half_sel};
      default: load_data_c = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with valid/ready request/response and LATENCY wait states.
// Defining DMEM_STATS_EN adds load/store/error access counters.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned AW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]   stat_loads,
  output logic [31:0]   stat_stores,
  output logic [31:0]   stat_errs
`endif
);

  localparam int unsigned IW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_ready_d, resp_valid_d, resp_err_d;
  logic [31:0]      resp_rdata_d;

  logic             wr_q;
  logic [2:0]       f3_q;
  logic [AW-1:0]    addr_q;
  logic [31:0]      wdata_q;

  logic             accept_c, do_access_c;
  logic             acc_write;
  logic [2:0]       acc_f3;
  logic [AW-1:0]    acc_addr;
  logic [31:0]      acc_wdata;
  logic [IW-1:0]    acc_idx;
  logic             acc_err;
  logic [31:0]      rword;

  logic [3:0]       byte_en_c;
  logic [31:0]      wdata_aligned_c, load_data_c;

  logic [31:0]      mem [DEPTH_WORDS];

  assign accept_c = req_valid && req_ready && (state_q == IDLE);

  // Zero-latency accesses use the live request; otherwise the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_f3    = req_funct3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_write = wr_q;
      acc_f3    = f3_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_idx = acc_addr[IW+1:2];
    acc_err = ((acc_addr >> (IW + 2)) != '0)
            || is_misaligned(acc_f3, acc_addr[1:0])
            || is_illegal_f3(acc_write, acc_f3);
    rword   = mem[acc_idx];
  end

  dmem_lane_align u_lane_align (
    .funct3          (acc_f3),
    .addr_lo         (acc_addr[1:0]),
    .wdata           (acc_wdata),
    .rword           (rword),
    .byte_en_c       (byte_en_c),
    .wdata_aligned_c (wdata_aligned_c),
    .load_data_c     (load_data_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    do_access_c  = 1'b0;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY == 0) begin
            do_access_c = 1'b1;
            state_d     = RESP;
          end else begin
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          do_access_c = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (do_access_c) begin
      resp_err_d   = acc_err;
      resp_rdata_d = (acc_err || acc_write) ? 32'h0 : load_data_c;
    end
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else if (accept_c) begin
      wr_q    <= req_write;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage is not reset; a reset in WAIT leaves the FSM idle so no write happens.
  always_ff @(posedge clk) begin
    if (do_access_c && acc_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en_c[b]) mem[acc_idx][8*b +: 8] <= wdata_aligned_c[8*b +: 8];
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_loads  <= 32'h0;
      stat_stores <= 32'h0;
      stat_errs   <= 32'h0;
    end else if (do_access_c) begin
      if (acc_err)        stat_errs   <= stat_errs + 32'd1;
      else if (acc_write) stat_stores <= stat_stores + 32'd1;
      else                stat_loads  <= stat_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: store/load lanes, errors, latency,
// backpressure and reset during an access.
module tb_data_mem_responder;

  localparam int unsigned LATENCY     = 2;
  localparam int unsigned DEPTH_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  int n_checks = 0;
  int n_fails  = 0;
  int m_loads  = 0;
  int m_stores = 0;
  int m_errs   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .LATENCY     (LATENCY),
    .AW          (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
`ifdef DMEM_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " req_ready"},  32'(req_ready),  32'd0);
    check_eq({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, " resp_err"},   32'(resp_err),   32'd0);
    check_eq({tag, " resp_rdata"}, resp_rdata,      32'h0);
  endtask

  // One full transaction; request fields are scrambled while waiting.
  task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    int guard;
    int edges;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = 1'b0;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, " accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_write  = ~wr;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFC;
    req_wdata  = 32'h0BAD_F00D;
    resp_ready = (hold == 0);
    edges = 1;
    while (!resp_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    req_valid = 1'b0;
    check_eq({tag, " latency"}, 32'(edges), 32'(LATENCY + 1));
    check_eq({tag, " rdata"},   resp_rdata, exp_rdata);
    check_eq({tag, " err"},     32'(resp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      check_eq({tag, " hold rdata"}, resp_rdata, exp_rdata);
      check_eq({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq({tag, " drop valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, " ready back"}, 32'(req_ready), 32'd1);
    if (exp_err)  m_errs++;
    else if (wr)  m_stores++;
    else          m_loads++;
  endtask

  task automatic check_stats(input string tag);
`ifdef DMEM_STATS_EN
    check_eq({tag, " loads"},  stat_loads,  32'(m_loads));
    check_eq({tag, " stores"}, stat_stores, 32'(m_stores));
    check_eq({tag, " errs"},   stat_errs,   32'(m_errs));
`else
    n_checks = n_checks + 0;
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  initial begin
    int guard;
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("release ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check_eq("post release ready", 32'(req_ready), 32'd1);

    run_req("sw 10",       1'b1, 3'b010, 32'h10,   32'hDEAD_BEEF, 32'h0,         1'b0, 0);
    run_req("lw 10",       1'b0, 3'b010, 32'h10,   32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    run_req("sw 10 zero",  1'b1, 3'b010, 32'h10,   32'h0,         32'h0,         1'b0, 0);
    run_req("sb 13",       1'b1, 3'b000, 32'h13,   32'h1234_5680, 32'h0,         1'b0, 0);
    run_req("lb 13",       1'b0, 3'b000, 32'h13,   32'h0,         32'hFFFF_FF80, 1'b0, 0);
    run_req("lbu 13",      1'b0, 3'b100, 32'h13,   32'h0,         32'h0000_0080, 1'b0, 0);
    run_req("lw 10 sb",    1'b0, 3'b010, 32'h10,   32'h0,         32'h8000_0000, 1'b0, 0);
    run_req("lh 11 mis",   1'b0, 3'b001, 32'h11,   32'h0,         32'h0,         1'b1, 0);
    run_req("sw 12 mis",   1'b1, 3'b010, 32'h12,   32'h1111_1111, 32'h0,         1'b1, 0);
    run_req("lw 10 keep",  1'b0, 3'b010, 32'h10,   32'h0,         32'h8000_0000, 1'b0, 0);
    run_req("lw range",    1'b0, 3'b010, 32'(DEPTH_WORDS * 4), 32'h0, 32'h0,     1'b1, 0);
    run_req("lw high bit", 1'b0, 3'b010, 32'h8000_0010, 32'h0,    32'h0,         1'b1, 0);
    run_req("sh 12",       1'b1, 3'b001, 32'h12,   32'hBEEF_A5C3, 32'h0,         1'b0, 0);
    run_req("lh 12",       1'b0, 3'b001, 32'h12,   32'h0,         32'hFFFF_A5C3, 1'b0, 0);
    run_req("lhu 12",      1'b0, 3'b101, 32'h12,   32'h0,         32'h0000_A5C3, 1'b0, 0);
    run_req("lb 12",       1'b0, 3'b000, 32'h12,   32'h0,         32'hFFFF_FFC3, 1'b0, 0);
    run_req("lbu 11",      1'b0, 3'b100, 32'h11,   32'h0,         32'h0,         1'b0, 0);
    run_req("sh 10",       1'b1, 3'b001, 32'h10,   32'h0000_7F01, 32'h0,         1'b0, 0);
    run_req("lh 10",       1'b0, 3'b001, 32'h10,   32'h0,         32'h0000_7F01, 1'b0, 0);
    run_req("load f3 011", 1'b0, 3'b011, 32'h10,   32'h0,         32'h0,         1'b1, 0);
    run_req("store f3 100",1'b1, 3'b100, 32'h10,   32'hFFFF_FFFF, 32'h0,         1'b1, 0);
    run_req("lw 10 bp",    1'b0, 3'b010, 32'h10,   32'h0,         32'hA5C3_7F01, 1'b0, 5);
    run_req("sw 20",       1'b1, 3'b010, 32'h20,   32'hCAFE_F00D, 32'h0,         1'b0, 0);
    run_req("sw last",     1'b1, 3'b010, 32'hFFC,  32'h5A5A_5A5A, 32'h0,         1'b0, 0);
    run_req("lw last",     1'b0, 3'b010, 32'hFFC,  32'h0,         32'h5A5A_5A5A, 1'b0, 0);
    check_stats("stats");

    // Reset while a store is waiting: it must be abandoned.
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h1234_5678;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rst wait accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("rst wait");
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst held ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_loads  = 0;
    m_stores = 0;
    m_errs   = 0;
    check_stats("stats after rst");
    run_req("lw 20 after rst", 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    check_stats("stats final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the data-memory load/store interface driven by the pipeline MEM stage. Accepts one request at a time over a valid/ready handshake.
- Stores are executed as byte, half or word writes.
- Loads return sign- or zero-extended data after a configurable number of wait states.
- Replaces the fixed single-cycle memory so the pipeline can be exercised against realistic memory latency.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the storage array; must be a power of two.
- LATENCY, 2, wait-state cycles between request acceptance and the array access; range 0..15.
- AW, 32, width of the request byte address.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V load/store funct3.
- req_addr  input  AW  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or illegal funct3.

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock.
  - While rst=1 and on release: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, state=IDLE, wait counter=0.
  - Array contents are not reset.
- FSM states and transitions:
  - IDLE: req_ready=1.
    - req_valid & req_ready at a rising edge latches write, funct3, addr and wdata.
    - LATENCY>0: counter=LATENCY-1, go to WAIT.
    - LATENCY=0: perform the access on the same edge, go to RESP.
  - WAIT: req_ready=0; counter decrements each cycle. When counter=0, perform the access on that edge and go to RESP.
  - RESP: resp_valid=1; rdata and err are held stable. When resp_ready=1, go to IDLE.
- Latency: resp_valid asserts LATENCY+1 cycles after the acceptance edge.
  - A new request is accepted no earlier than the cycle after the response handshake, so there is no overlap.
- Access and error rules:
  - Word index is addr[log2(DEPTH_WORDS)+1:2].
  - err=1 when any of the following holds:
    - address bits above the index are nonzero;
    - funct3 is 001/101 and addr[0]=1;
    - funct3 is 010 and addr[1:0]!=0;
    - store funct3 is not 000/001/010;
    - load funct3 is not 000/001/010/100/101.
  - On err: no array write, rdata=0.
- Stores: sb writes byte lane addr[1:0] from wdata[7:0]; sh writes lanes {addr[1],0} from wdata[15:0]; sw writes all four lanes. Other lanes are untouched. rdata=0.
- Loads:
  - lb/lh sign-extend from bit 7/15 of the selected lane.
  - lbu/lhu zero-extend.
  - lw returns the full word.
- Store followed by a load to the same word returns the newly written data.
- Boundary conditions:
  - req_valid held high through WAIT/RESP has no effect; the request fields may change freely.
  - resp_ready high before resp_valid is ignored.
  - Reset asserted in WAIT: the access is abandoned and the pending store is not written.
  - Reset asserted in RESP: the response is dropped.

Optional Feature:
- DMEM_STATS_EN defined adds 32-bit outputs stat_loads, stat_stores and stat_errs.
  - Each increments by one on the edge that performs an access of that class; an errored access counts only as an error.
  - Counters wrap at 2^32 and reset to 0 on rst.
- Without the macro these ports and counters do not exist; the behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg contains:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - state encoding IDLE/WAIT/RESP;
  - function is_misaligned(funct3, addr[1:0]).
- One combinational sub-module, dmem_lane_align: produces byte enables plus shifted write data for stores, and the extracted/extended load value from the word and addr[1:0].

Test Plan:
- LATENCY=2: sw 0xDEADBEEF @0x10, then lw @0x10 -> rdata=0xDEADBEEF, err=0; resp_valid rises 3 cycles after each acceptance.
- sb 0x80 @0x13 over word 0x00000000, then lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lw @0x10 -> 0x80000000.
- lh @0x11 -> err=1, rdata=0. sw @0x12 -> err=1 and the word is unchanged. lw @(DEPTH_WORDS*4) -> err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and req_ready=0 stay stable; accept on the cycle after resp_ready=1.
- Assert rst mid-WAIT of sw 0x12345678 @0x20 -> outputs reset immediately; a later lw @0x20 returns the prior contents.
- With DMEM_STATS_EN: 3 loads, 2 stores, 1 misaligned load -> stat_loads=3, stat_stores=2, stat_errs=1.
